// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: memory bus types, FSM states and register record for the fetch buffer
package fetch_buffer_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fb_state_type;

    typedef struct packed {
        logic [31:0]  base;
        logic [31:0]  count;
        logic [31:0]  paddr;
        fb_state_type state;
        logic         imem_valid;
        logic [31:0]  imem_addr;
    } fetch_buffer_reg_type;

    localparam fetch_buffer_reg_type init_fetch_buffer_reg = '{
        base:       32'h0,
        count:      32'h0,
        paddr:      32'h0,
        state:      IDLE,
        imem_valid: 1'b0,
        imem_addr:  32'h0
    };

endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: request/response pair of one memory port
interface fetch_buffer_if;
    import fetch_buffer_pkg::*;

    mem_in_type  mem_in;
    mem_out_type mem_out;

    modport master (output mem_in, input mem_out);
    modport slave  (input mem_in, output mem_out);
endinterface

// File: rtl/fetch_buffer_ram.sv
// fetch_buffer_ram: DEPTH x 16 halfword store, two async read ports, two write ports
module fetch_buffer_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we0_i,
    input  logic [AW-1:0] wa0_i,
    input  logic [15:0]   wd0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] wa1_i,
    input  logic [15:0]   wd1_i,
    input  logic [AW-1:0] ra0_i,
    input  logic [AW-1:0] ra1_i,
    output logic [15:0]   rd0_o,
    output logic [15:0]   rd1_o
);

    logic [15:0] mem_q [DEPTH];

    // both halves of a returned word land in adjacent slots, never the same one
    always_ff @(posedge clk_i) begin
        if (we0_i) mem_q[wa0_i] <= wd0_i;
        if (we1_i) mem_q[wa1_i] <= wd1_i;
    end

    assign rd0_o = mem_q[ra0_i];
    assign rd1_o = mem_q[ra1_i];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: prefetching halfword buffer answering fetch requests in the same cycle
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    fetch_buffer_if.slave  fetchbuffer,
    fetch_buffer_if.master imem
);

    localparam int AW = $clog2(DEPTH);

    fetch_buffer_reg_type r_q, r_d;
    mem_in_type           req, imem_req;
    mem_out_type          rsp, fb_rsp;

    logic [31:0]   a, off, span, endp, cnt_c;
    logic [15:0]   hw0, hw1;
    logic [AW-1:0] ra0, ra1, wa0, wa1;
    logic          hw0_p, hw1_p, in_win, comp, flush, hit, retire, fill, we0, issue;
    logic          unused_ok;

    assign req  = fetchbuffer.mem_in;
    assign rsp  = imem.mem_out;
    assign a    = req.mem_addr;
    assign span = r_q.count << 1;
    assign off  = a - r_q.base;
    assign endp = r_q.base + span;

    assign ra0 = a[AW:1];
    assign ra1 = ra0 + AW'(1);
    assign wa0 = r_q.paddr[AW:1];
    assign wa1 = wa0 + AW'(1);

    // the halfword just past the window is pending data, so it counts as in-window (wait, not flush)
    assign hw0_p  = off < span;
    assign hw1_p  = (off + 32'd2) < span;
    assign in_win = off <= span;
    assign comp   = hw0[1:0] != 2'b11;
    assign flush  = req.mem_valid & (req.mem_spec | req.mem_fence | ~in_win);
    assign hit    = req.mem_valid & ~req.mem_fence & ~req.mem_spec & hw0_p & (comp | hw1_p);
    assign retire = req.mem_valid & in_win & ~flush;
    assign cnt_c  = retire ? r_q.count - (off >> 1) : r_q.count;
    assign issue  = (r_q.state == IDLE) & ~flush & (cnt_c <= 32'(DEPTH - 2));

    // a word whose low half lies below base (misaligned redirect) only contributes its upper half
    assign fill = rsp.mem_ready & (r_q.state == WAIT) & ~flush;
    assign we0  = fill & (endp == r_q.paddr);

    assign unused_ok = ^{req.mem_wdata, req.mem_wstrb, req.mem_instr};

    fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i (clock),
        .we0_i (we0),
        .wa0_i (wa0),
        .wd0_i (rsp.mem_rdata[15:0]),
        .we1_i (fill),
        .wa1_i (wa1),
        .wd1_i (rsp.mem_rdata[31:16]),
        .ra0_i (ra0),
        .ra1_i (ra1),
        .rd0_o (hw0),
        .rd1_o (hw1)
    );

    // next state: consume, fill and flush, with flush overriding both
    always_comb begin
        r_d            = r_q;
        r_d.base       = (flush | retire) ? a : r_q.base;
        r_d.count      = flush ? 32'h0 : cnt_c + (fill ? (we0 ? 32'd2 : 32'd1) : 32'd0);
        r_d.paddr      = flush ? {a[31:2], 2'b00} : fill ? r_q.paddr + 32'd4 : r_q.paddr;
        r_d.state      = issue ? WAIT : rsp.mem_ready ? IDLE : (r_q.state == WAIT && flush) ? DROP : r_q.state;
        r_d.imem_valid = issue;
        r_d.imem_addr  = issue ? r_q.paddr : r_q.imem_addr;
    end

    // state register; reset abandons any in-flight prefetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_q <= init_fetch_buffer_reg;
        else        r_q <= r_d;
    end

    // instruction-memory request: one-cycle pulse from registered state
    always_comb begin
        imem_req           = '0;
        imem_req.mem_valid = r_q.imem_valid;
        imem_req.mem_instr = 1'b1;
        imem_req.mem_addr  = r_q.imem_addr;
    end

    // fetch response: zero unless the whole instruction is buffered
    always_comb begin
        fb_rsp           = '0;
        fb_rsp.mem_ready = hit;
        fb_rsp.mem_rdata = hit ? (comp ? {16'h0, hw0} : {hw1, hw0}) : 32'h0;
    end

    assign imem.mem_in        = imem_req;
    assign fetchbuffer.mem_out = fb_rsp;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of the fetch buffer against a simple instruction memory
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hold  = 1'b0;
    logic        pend;
    logic        seen_v;
    logic [31:0] maddr;
    logic [31:0] iss_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          nidx;

    fetch_buffer_if fb_if ();
    fetch_buffer_if imem_if ();

    fetch_buffer #(.DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetchbuffer (fb_if),
        .imem        (imem_if)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h4501_4581;
            32'h8:   return 32'h0013_0001;
            32'hC:   return 32'h2222_0000;
            default: return {a[15:0] + 16'd2, a[15:0]};
        endcase
    endfunction

    // instruction memory: answers two edges after the request unless held
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend            <= 1'b0;
            imem_if.mem_out <= '0;
        end else if (imem_if.mem_in.mem_valid) begin
            pend            <= 1'b1;
            maddr           <= imem_if.mem_in.mem_addr;
            imem_if.mem_out <= '0;
        end else if (pend && !hold) begin
            pend            <= 1'b0;
            imem_if.mem_out <= {1'b1, word(maddr)};
        end else begin
            imem_if.mem_out <= '0;
        end
    end

    always @(posedge clock)
        if (reset && imem_if.mem_in.mem_valid) iss_q.push_back(imem_if.mem_in.mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [31:0] a);
        mem_in_type r;
        r           = '0;
        r.mem_valid = v;
        r.mem_spec  = s;
        r.mem_fence = f;
        r.mem_instr = 1'b1;
        r.mem_addr  = a;
        fb_if.mem_in = r;
    endtask

    task automatic wait_hit(input int bound);
        for (int i = 0; i < bound && !fb_if.mem_out.mem_ready; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && !imem_if.mem_out.mem_ready; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_issue(input int bound);
        for (int i = 0; i < bound && !imem_if.mem_in.mem_valid; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_ready", 32'(fb_if.mem_out.mem_ready), 32'h0);
        check("rst_rdata", fb_if.mem_out.mem_rdata, 32'h0);
        check("rst_imem_valid", 32'(imem_if.mem_in.mem_valid), 32'h0);

        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        wait_rsp(20);
        check("first_rsp_seen", 32'(imem_if.mem_out.mem_ready), 32'h1);
        check("first_ready_before_fill", 32'(fb_if.mem_out.mem_ready), 32'h0);
        @(negedge clock);
        #1;
        check("first_ready", 32'(fb_if.mem_out.mem_ready), 32'h1);
        check("first_rdata", fb_if.mem_out.mem_rdata, 32'h0000_0013);
        check("first_imem_addr", iss_q.size() > 0 ? iss_q[0] : 32'hdead_beef, 32'h0);

        repeat (30) @(negedge clock);
        seen_v = 1'b0;
        repeat (10) begin
            @(negedge clock);
            seen_v |= imem_if.mem_in.mem_valid;
        end
        check("full_no_prefetch", 32'(seen_v), 32'h0);
        check("full_issue_count", 32'(iss_q.size()), 32'd4);
        check("full_last_addr", iss_q.size() > 3 ? iss_q[3] : 32'hdead_beef, 32'hC);

        drive(1'b1, 1'b0, 1'b0, 32'h4);
        #1;
        check("comp_lo", fb_if.mem_out.mem_rdata, 32'h0000_4581);
        @(negedge clock);
        #1;
        check("refill_valid", 32'(imem_if.mem_in.mem_valid), 32'h1);
        check("refill_addr", imem_if.mem_in.mem_addr, 32'h10);
        drive(1'b1, 1'b0, 1'b0, 32'h6);
        #1;
        check("comp_hi", fb_if.mem_out.mem_rdata, 32'h0000_4501);

        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 32'h8);
        #1;
        check("fence_ready", 32'(fb_if.mem_out.mem_ready), 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h8);
        #1;
        wait_hit(30);
        check("refetch8_rdata", fb_if.mem_out.mem_rdata, 32'h0000_0001);
        hold = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'hA);
        #1;
        seen_v = fb_if.mem_out.mem_ready;
        repeat (5) begin
            @(negedge clock);
            #1;
            seen_v |= fb_if.mem_out.mem_ready;
        end
        check("straddle_wait", 32'(seen_v), 32'h0);
        hold = 1'b0;
        wait_rsp(10);
        check("straddle_rsp_seen", 32'(imem_if.mem_out.mem_ready), 32'h1);
        @(negedge clock);
        #1;
        check("straddle_rdata", fb_if.mem_out.mem_rdata, 32'h0000_0013);

        hold = 1'b1;
        wait_issue(20);
        check("redir_pending_addr", imem_if.mem_in.mem_addr, 32'h10);
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h102);
        #1;
        check("redir_flush_ready", 32'(fb_if.mem_out.mem_ready), 32'h0);
        @(negedge clock);
        nidx = iss_q.size();
        drive(1'b1, 1'b0, 1'b0, 32'h102);
        hold = 1'b0;
        #1;
        wait_hit(30);
        check("redir_rdata", fb_if.mem_out.mem_rdata, 32'h0000_0102);
        check("redir_imem_addr", iss_q.size() > nidx ? iss_q[nidx] : 32'hdead_beef, 32'h100);

        hold = 1'b1;
        wait_issue(20);
        check("wait_issue_seen", 32'(imem_if.mem_in.mem_valid), 32'h1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_imem_valid", 32'(imem_if.mem_in.mem_valid), 32'h0);
        check("midrst_ready", 32'(fb_if.mem_out.mem_ready), 32'h0);
        check("midrst_rdata", fb_if.mem_out.mem_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        hold  = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h200);
        nidx = iss_q.size();
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h200);
        #1;
        wait_hit(30);
        check("postrst_imem_addr", iss_q.size() > nidx ? iss_q[nidx] : 32'hdead_beef, 32'h200);
        check("postrst_rdata", fb_if.mem_out.mem_rdata, 32'h0000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
